serv_shift_seq: RTL and testbench
=================================

SERV_SHIFT_SEQ -- requirements
Module: serv_shift_seq

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 32 bits and shift amount at 6 bits.
REQ-002 i_clk  in  1  single clock; all state SHALL update on rising edge only.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_cmd_valid  in  1  command offered.
REQ-005 o_cmd_ready  out  1  command accepted when i_cmd_valid & o_cmd_ready at a rising edge.
REQ-006 i_cmd_op  in  2  00=SLL, 01=SRL, 11=SRA, 10=reserved (treated as SLL).
REQ-007 i_cmd_data  in  32  operand.
REQ-008 i_cmd_shamt  in  6  shift amount; bit 5 is the MSB.
REQ-009 o_sh_load  out  1  load strobe to bit-serial shifter.
REQ-010 o_sh_shamt  out  5  shamt[4:0] to shifter.
REQ-011 o_sh_shamt_msb  out  1  shamt[5] to shifter.
REQ-012 o_sh_right  out  1  1 for SRL/SRA.
REQ-013 o_sh_signbit  out  1  operand bit 31 when op=SRA, else 0.
REQ-014 i_sh_done  in  1  shifter count-reached flag.
REQ-015 o_sh_d  out  1  serial operand bit to shifter.
REQ-016 i_sh_q  in  1  serial result bit from shifter.
REQ-017 o_rsp_valid  out  1  result available.
REQ-018 i_rsp_ready  in  1  result consumed when o_rsp_valid & i_rsp_ready at a rising edge.
REQ-019 o_rsp_data  out  32  shift result.
REQ-020 o_busy  out  1  high in every state except IDLE.

Function
REQ-021 SHALL implement states IDLE, LOAD, WAIT, STREAM, RESP.
REQ-022 IDLE: o_cmd_ready=1; on accept, latch op, data and shamt into command registers and go to LOAD.
REQ-023 o_cmd_ready SHALL be 0 in all states except IDLE; at most one command is in flight, with no queuing.
REQ-024 o_sh_shamt, o_sh_shamt_msb, o_sh_right and o_sh_signbit SHALL be driven from the command registers only, stable from LOAD through the end of STREAM.
REQ-025 LOAD: exactly one cycle with o_sh_load=1, then go to WAIT; o_sh_load SHALL be 0 in all other states.
REQ-026 WAIT: remain until i_sh_done=1 is sampled; i_sh_done is ignored in all other states.
REQ-027 On leaving WAIT, go to STREAM and clear the 5-bit bit counter k.
REQ-028 STREAM: each cycle, o_sh_d = data[k] (LSB first) and i_sh_q is captured into result bit k.
REQ-029 After k=31 is captured (32 cycles, k wraps 31->0), go to RESP.
REQ-030 o_sh_d SHALL be 0 outside STREAM.
REQ-031 RESP: o_rsp_valid=1 and o_rsp_data = the captured result, both held stable until handshake.
REQ-032 On RESP handshake, return to IDLE; a new command is acceptable from the following cycle, not in the same cycle.
REQ-033 o_rsp_data SHALL retain its last value in IDLE.
REQ-034 Latency with i_sh_done already high: accept edge T, LOAD at T+1, WAIT at T+2, STREAM T+3..T+34, o_rsp_valid from T+35; total 35 cycles. Each extra WAIT cycle adds 1.
REQ-035 Reserved op 10 SHALL set o_sh_right=0 and o_sh_signbit=0.

Reset
REQ-036 While i_rst_n=0 at a rising edge, the block SHALL enter IDLE and set o_rsp_valid=0, o_sh_load=0, o_busy=0, k=0, result=0 and command registers=0; o_cmd_ready is 1 after reset.
REQ-037 A reset in any state, including mid-STREAM or in RESP, SHALL abort the operation with no response emitted; behaviour is identical to power-up.

Verification
REQ-038 Loopback: i_sh_q tied to o_sh_d, i_sh_done=1; SRL data 0xDEADBEEF, shamt 3 -> o_rsp_valid at T+35 with o_rsp_data=0xDEADBEEF, o_sh_right=1, o_sh_signbit=0, one o_sh_load pulse at T+1.
REQ-039 SRA data 0x80000001, shamt 0x21 -> o_sh_signbit=1, o_sh_right=1, o_sh_shamt=1, o_sh_shamt_msb=1 for T+1..T+34.
REQ-040 i_sh_done held 0 for 10 WAIT cycles, then 1 -> STREAM begins 1 cycle later; o_rsp_valid appears at T+45.
REQ-041 i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid and o_rsp_data stay stable, o_cmd_ready=0 throughout; after handshake, o_cmd_ready=1 the next cycle.
REQ-042 i_rst_n=0 for one cycle at stream bit k=12 -> next cycle IDLE, o_busy=0, o_rsp_valid=0, result=0; a following command completes normally.
REQ-043 i_cmd_valid held during an operation -> no second accept until IDLE; exactly one response per accepted command.

Source files
------------

// File: rtl/serv_shift_seq.sv
// Sequencer that feeds one 32-bit shift command through an external bit-serial shifter.
// Latency: 35 cycles from command accept to response valid, plus one per extra WAIT cycle.
// Backpressure: one command in flight; cmd_ready only in IDLE, response held until i_rsp_ready.
module serv_shift_seq (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [1:0]  i_cmd_op,
    input  logic [31:0] i_cmd_data,
    input  logic [5:0]  i_cmd_shamt,
    output logic        o_sh_load,
    output logic [4:0]  o_sh_shamt,
    output logic        o_sh_shamt_msb,
    output logic        o_sh_right,
    output logic        o_sh_signbit,
    input  logic        i_sh_done,
    output logic        o_sh_d,
    input  logic        i_sh_q,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] OP_SRA = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [5:0]  shamt_q, shamt_d;
    logic [4:0]  k_q, k_d;
    logic [31:0] result_q, result_d;

    // Shifter control comes only from the latched command, so it cannot glitch mid-operation.
    // op bit 0 marks the right shifts (01 SRL, 11 SRA); reserved 10 falls out as a left shift.
    assign o_sh_shamt     = shamt_q[4:0];
    assign o_sh_shamt_msb = shamt_q[5];
    assign o_sh_right     = op_q[0];
    assign o_sh_signbit   = (op_q == OP_SRA) ? data_q[31] : 1'b0;
    assign o_rsp_data     = result_q;
    assign o_busy         = (state_q != ST_IDLE);

    // Next-state, command capture, serial streaming and handshake outputs.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        shamt_d     = shamt_q;
        k_d         = k_q;
        result_d    = result_q;
        o_cmd_ready = 1'b0;
        o_sh_load   = 1'b0;
        o_sh_d      = 1'b0;
        o_rsp_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    op_d    = i_cmd_op;
                    data_d  = i_cmd_data;
                    shamt_d = i_cmd_shamt;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_sh_load = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_sh_done) begin
                    k_d     = 5'd0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // LSB first: bit k goes out and the shifter's bit k comes back the same cycle.
                o_sh_d        = data_q[k_q];
                result_d[k_q] = i_sh_q;
                k_d           = k_q + 5'd1;
                if (k_q == 5'd31) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears everything.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'b00;
            data_q   <= 32'd0;
            shamt_q  <= 6'd0;
            k_q      <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            shamt_q  <= shamt_d;
            k_q      <= k_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_serv_shift_seq.sv
// Directed bench for serv_shift_seq; shifter is emulated as loopback or inverted loopback.
// Cycle label n = the cycle after the n-th rising edge counted from the accept edge (n=1 is LOAD).
// Outputs are sampled on the falling edge, inputs are driven on the falling edge.
module tb_serv_shift_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [5:0]  cmd_shamt;
    logic        sh_load;
    logic [4:0]  sh_shamt;
    logic        sh_shamt_msb;
    logic        sh_right;
    logic        sh_signbit;
    logic        sh_done;
    logic        sh_d;
    logic        sh_q;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;
    logic        inv_mode;

    int n_checks = 0;
    int n_fail   = 0;

    assign sh_q = inv_mode ? ~sh_d : sh_d;

    serv_shift_seq dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_op       (cmd_op),
        .i_cmd_data     (cmd_data),
        .i_cmd_shamt    (cmd_shamt),
        .o_sh_load      (sh_load),
        .o_sh_shamt     (sh_shamt),
        .o_sh_shamt_msb (sh_shamt_msb),
        .o_sh_right     (sh_right),
        .o_sh_signbit   (sh_signbit),
        .i_sh_done      (sh_done),
        .o_sh_d         (sh_d),
        .i_sh_q         (sh_q),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [5:0]  shamt;
        logic        inv;
        logic        exp_right;
        logic        exp_sign;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one command and follow it to the response handshake.
    task automatic run_cmd(input vec_t v, input int waitc, input int stall, input bit hold);
        int n, loads, load_at, first_vld, stalled;
        int ctl_bad, rdy_bad, shd_bad, stab_bad;
        bit hs;
        logic [31:0] held;
        @(negedge clk);
        inv_mode  = v.inv;
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_data  = v.data;
        cmd_shamt = v.shamt;
        sh_done   = (waitc == 0);
        rsp_ready = 1'b0;
        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        n = 0; loads = 0; load_at = 0; first_vld = 0; stalled = 0;
        ctl_bad = 0; rdy_bad = 0; shd_bad = 0; stab_bad = 0; hs = 1'b0; held = '0;
        while (!hs && n < 300) begin
            @(negedge clk);
            n++;
            if (!hold) cmd_valid = 1'b0;
            sh_done = (n >= waitc + 2);
            if (sh_load) begin
                loads++;
                load_at = n;
            end
            if (cmd_ready) rdy_bad++;
            if (n <= 34 + waitc) begin
                if (sh_shamt !== v.shamt[4:0] || sh_shamt_msb !== v.shamt[5] ||
                    sh_right !== v.exp_right || sh_signbit !== v.exp_sign) ctl_bad++;
            end
            if ((n <= waitc + 2 || rsp_valid) && sh_d) shd_bad++;
            if (rsp_valid) begin
                if (first_vld == 0) begin
                    first_vld = n;
                    held = rsp_data;
                end else if (rsp_data !== held) begin
                    stab_bad++;
                end
                if (stalled == stall) begin
                    rsp_ready = 1'b1;
                    hs = 1'b1;
                end else begin
                    stalled++;
                end
            end
        end
        check("handshake_seen", {31'd0, hs}, 32'd1);
        check("load_pulses", loads, 1);
        check("load_cycle", load_at, 1);
        check("rsp_latency", first_vld, 35 + waitc);
        check("sh_ctl_bad_cycles", ctl_bad, 0);
        check("cmd_ready_busy_cycles", rdy_bad, 0);
        check("sh_d_outside_stream", shd_bad, 0);
        check("rsp_unstable_cycles", stab_bad, 0);
        check("rsp_data", held, v.exp_result);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_busy", {31'd0, busy}, 32'd0);
        check("post_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_hs_rsp_data", rsp_data, v.exp_result);
        cmd_valid = 1'b0;
    endtask

    initial begin
        vec_t va;
        int vld_seen;
        //          op     data          shamt  inv   right sign  result
        vecs[0] = '{2'b01, 32'hDEADBEEF, 6'd3,  1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{2'b11, 32'h80000001, 6'h21, 1'b0, 1'b1, 1'b1, 32'h80000001};
        vecs[2] = '{2'b11, 32'h7FFFFFFF, 6'd5,  1'b1, 1'b1, 1'b0, 32'h80000000};
        vecs[3] = '{2'b00, 32'hFFFFFFFF, 6'h3F, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF};
        vecs[4] = '{2'b10, 32'h80000000, 6'd7,  1'b1, 1'b0, 1'b0, 32'h7FFFFFFF};
        vecs[5] = '{2'b00, 32'h12345678, 6'h10, 1'b1, 1'b0, 1'b0, 32'hEDCBA987};
        vecs[6] = '{2'b01, 32'h00000000, 6'h20, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0; cmd_shamt = '0;
        sh_done = 1'b0; rsp_ready = 1'b0; inv_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_sh_load", {31'd0, sh_load}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_sh_ctl", {26'd0, sh_signbit, sh_right, sh_shamt_msb, sh_shamt[2:0]}, 32'd0);

        for (int i = 0; i < 7; i++) run_cmd(vecs[i], 0, 0, 1'b0);

        // Shifter slow to finish: ten WAIT cycles with done low.
        run_cmd(vecs[0], 10, 0, 1'b0);
        // Consumer stalls the response for five cycles.
        run_cmd(vecs[1], 0, 5, 1'b0);
        // Command valid held throughout: only one accept, none on the handshake edge.
        run_cmd(vecs[5], 0, 2, 1'b1);

        // Reset pulse while streaming bit k=12 (STREAM starts at cycle 3 with k=0).
        va = vecs[3];
        @(negedge clk);
        inv_mode = va.inv; cmd_valid = 1'b1; cmd_op = va.op; cmd_data = va.data;
        cmd_shamt = va.shamt; sh_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (14) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_result", rsp_data, 32'd0);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        vld_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || busy) vld_seen++;
        end
        check("abort_no_response", vld_seen, 0);
        run_cmd(vecs[2], 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
